// File: rtl/data_mem_responder_if.sv
// Request/response bus between the M1 memory pipeline stage and the data memory responder.
interface data_mem_responder_if;
   logic        m1_req_valid;
   logic        m1_req_ready;
   logic        m1_req_readmem;
   logic        m1_req_writemem;
   logic [6:0]  m1_req_addr;
   logic [31:0] m1_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic        mem_resp_write;
   logic        mem_err;

   modport master (
      output m1_req_valid, m1_req_readmem, m1_req_writemem, m1_req_addr, m1_req_wdata,
      input  m1_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_write, mem_err
   );

   modport slave (
      input  m1_req_valid, m1_req_readmem, m1_req_writemem, m1_req_addr, m1_req_wdata,
      output m1_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_write, mem_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-request data memory: 128 x 32-bit array with a fixed number of wait states
// between acceptance and a one-cycle response strobe.
module data_mem_responder #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   data_mem_responder_if.slave   mem_if
);
   localparam int unsigned AW    = 7;
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = 3;
   localparam int unsigned DEPTH = 128;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            rd_q, rd_d, wr_q, wr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            ready_q, resp_valid_q;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            write_q, write_d, err_q, err_d;
   logic            access_c;
   logic [AW-1:0]   acc_addr_c;
   logic            acc_rd_c, acc_wr_c;
   logic [DW-1:0]   acc_wdata_c;
   logic [DW-1:0]   mem_q [DEPTH];

   // Next state; the access uses the live request when there are no wait states
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      access_c    = 1'b0;
      acc_addr_c  = addr_q;
      acc_rd_c    = rd_q;
      acc_wr_c    = wr_q;
      acc_wdata_c = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_if.m1_req_valid) begin
               addr_d  = mem_if.m1_req_addr;
               rd_d    = mem_if.m1_req_readmem;
               wr_d    = mem_if.m1_req_writemem;
               wdata_d = mem_if.m1_req_wdata;
               if (WAIT_STATES == 0) begin
                  state_d     = ST_RESP;
                  access_c    = 1'b1;
                  acc_addr_c  = mem_if.m1_req_addr;
                  acc_rd_c    = mem_if.m1_req_readmem;
                  acc_wr_c    = mem_if.m1_req_writemem;
                  acc_wdata_c = mem_if.m1_req_wdata;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CW'(WAIT_STATES);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CW'(1)) begin
               state_d  = ST_RESP;
               cnt_d    = '0;
               access_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      rdata_d = rdata_q;
      write_d = write_q;
      err_d   = err_q;
      if (access_c) begin
         err_d   = acc_rd_c & acc_wr_c;
         write_d = acc_wr_c & ~acc_rd_c;
         rdata_d = (acc_rd_c & ~acc_wr_c) ? mem_q[acc_addr_c] : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Latched request and registered response fields
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q       <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         ready_q      <= (state_d == ST_IDLE);
         resp_valid_q <= access_c;
         rdata_q      <= rdata_d;
         write_q      <= write_d;
         err_q        <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (access_c && acc_wr_c && !acc_rd_c) begin
         mem_q[acc_addr_c] <= acc_wdata_c;
      end
   end

   assign mem_if.m1_req_ready   = ready_q;
   assign mem_if.mem_resp_valid = resp_valid_q;
   assign mem_if.mem_resp_rdata = rdata_q;
   assign mem_if.mem_resp_write = write_q;
   assign mem_if.mem_err        = err_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving extra access cycles (legal range 0..7).
REQ-002 The block SHALL provide clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL provide m1_req_valid  input  1  request present from the memory pipeline M1 stage.
REQ-005 The block SHALL provide m1_req_ready  output  1  responder can accept a request this cycle.
REQ-006 The block SHALL provide m1_req_readmem  input  1  request is a load.
REQ-007 The block SHALL provide m1_req_writemem  input  1  request is a store.
REQ-008 The block SHALL provide m1_req_addr  input  7  word address, 128 x 32-bit array.
REQ-009 The block SHALL provide m1_req_wdata  input  32  store data.
REQ-010 The block SHALL provide mem_resp_valid  output  1  one-cycle response strobe.
REQ-011 The block SHALL provide mem_resp_rdata  output  32  load data.
REQ-012 The block SHALL provide mem_resp_write  output  1  the response acknowledges a store.
REQ-013 The block SHALL provide mem_err  output  1  the request had both readmem and writemem set.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE, m1_req_ready SHALL be 1; ready SHALL be 0 in WAIT and RESP.
REQ-016 On a rising edge with valid=1 and ready=1, the block SHALL latch addr, readmem, writemem and wdata, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-017 req_valid while ready=0 SHALL be ignored; request inputs SHALL NOT be sampled outside IDLE.
REQ-018 WAIT SHALL hold for exactly WAIT_STATES cycles via a down-counter loaded at acceptance, then go to RESP.
REQ-019 The array access SHALL occur on the edge entering RESP: store writes array[addr] <= wdata; load registers array[addr] into mem_resp_rdata.
REQ-020 Latency: for acceptance at edge E0, mem_resp_valid SHALL be 1 for exactly the cycle following edge E0+WAIT_STATES.
REQ-021 RESP SHALL last one cycle, then go to IDLE; no response backpressure exists; peak throughput is one request per WAIT_STATES+2 cycles.
REQ-022 A store response SHALL drive mem_resp_write=1 and mem_resp_rdata=0.
REQ-023 A load response SHALL drive mem_resp_write=0 with the addressed word.
REQ-024 readmem=writemem=1 SHALL produce a response with mem_err=1, rdata=0, write=0 and no array update.
REQ-025 readmem=writemem=0 (NOP) SHALL produce a response with err=0, write=0, rdata=0.
REQ-026 mem_resp_rdata, mem_resp_write and mem_err SHALL hold their values until the next response and are meaningful only while mem_resp_valid=1.
REQ-027 A load following a store to the same address SHALL return the stored data.
REQ-028 Address arithmetic SHALL be 7-bit with no wrap beyond 127; addresses 0 and 127 SHALL be fully usable.

Reset
REQ-029 While reset=0, the FSM SHALL be IDLE, the wait counter 0, resp_valid/rdata/write/err 0, m1_req_ready 1 and all 128 array words 0.
REQ-030 Reset asserted mid-operation (WAIT or RESP) SHALL abort the request with no array write and no response.
REQ-031 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 WAIT_STATES=1: store addr 5 data 32'hDEAD_BEEF, then load addr 5 -> store response with write=1 one cycle after the WAIT cycle; load response with rdata=32'hDEAD_BEEF, err=0.
REQ-033 WAIT_STATES=0: back-to-back loads of addrs 0 and 127 after reset -> each response has rdata=0, is one cycle after acceptance and is spaced 2 cycles apart; ready toggles 1,0,1.
REQ-034 Request with readmem=writemem=1, addr 9, wdata 32'h1234_5678 -> err=1, rdata=0; a subsequent load of addr 9 returns 0.
REQ-035 WAIT_STATES=3: store accepted, reset pulsed low during WAIT -> no resp_valid, ready=1 after release, load of the same addr returns 0.
REQ-036 valid held high while ready=0 with changing addr/wdata -> only the request accepted in IDLE takes effect; exactly one response per acceptance.
